// File: rtl/security_pkg.sv
// rtl/security_pkg.sv - shared state encodings and default timing for the security alarm path
package security_pkg;

  // Monitor FSM encoding; benches compare state_o against these values directly
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUALIFY  = 2'd1,
    ALARM    = 2'd2,
    SILENCED = 2'd3
  } alarm_state_t;

  // Default consecutive al samples needed to qualify an alarm
  localparam int DEFAULT_DEBOUNCE = 3;

  // Default siren on-time in clk cycles
  localparam int DEFAULT_SIREN_CYCLES = 16;

  // Debounce counter width covers the full 1..15 DEBOUNCE range
  localparam int DEB_W = 4;

  // Siren timer width covers the full 1..255 SIREN_CYCLES range
  localparam int TIMER_W = 8;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  // Clear beats a coincident increment; the count holds once all ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != MAX_VAL)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/alarm_monitor.sv
// rtl/alarm_monitor.sv - debounced alarm FSM with timed siren and qualified-alarm counter
module alarm_monitor
  import security_pkg::*;
#(
  parameter int DEBOUNCE     = DEFAULT_DEBOUNCE,
  parameter int SIREN_CYCLES = DEFAULT_SIREN_CYCLES,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             al,
  input  logic             ack,
  input  logic             cnt_clr,
  output logic             siren,
  output logic             alarm_latched,
  output logic [CNT_W-1:0] alarm_count,
  output logic [1:0]       state_o
);

  // Debounce value seen on the edge that completes qualification
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE - 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(SIREN_CYCLES);

  alarm_state_t        state;
  logic [DEB_W-1:0]    deb_cnt;
  logic [TIMER_W-1:0]  timer;
  logic                alarm_entry;

  // High on the edge where the FSM moves into ALARM; feeds the counter
  always_comb begin
    alarm_entry = 1'b0;
    if (al) begin
      if ((state == IDLE) && (DEBOUNCE == 1)) begin
        alarm_entry = 1'b1;
      end else if ((state == QUALIFY) && (deb_cnt == DEB_LAST)) begin
        alarm_entry = 1'b1;
      end
    end
  end

  // Main FSM: debounce, siren timing and latch, all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      timer         <= '0;
      siren         <= 1'b0;
      alarm_latched <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (al) begin
            if (alarm_entry) begin
              state         <= ALARM;
              deb_cnt       <= '0;
              timer         <= TIMER_LOAD;
              siren         <= 1'b1;
              alarm_latched <= 1'b1;
            end else begin
              state   <= QUALIFY;
              deb_cnt <= DEB_W'(1);
            end
          end
        end

        QUALIFY: begin
          if (!al) begin
            state   <= IDLE;
            deb_cnt <= '0;
          end else if (alarm_entry) begin
            state         <= ALARM;
            deb_cnt       <= '0;
            timer         <= TIMER_LOAD;
            siren         <= 1'b1;
            alarm_latched <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        ALARM: begin
          // Ack and expiry share one exit so a coincidence cannot double count
          if (ack || (timer == TIMER_W'(1))) begin
            state <= SILENCED;
            timer <= '0;
            siren <= 1'b0;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end

        SILENCED: begin
          // Only a cleared input plus operator ack re-arms the monitor
          if (!al && ack) begin
            state         <= IDLE;
            alarm_latched <= 1'b0;
          end
        end

        default: begin
          state         <= IDLE;
          deb_cnt       <= '0;
          timer         <= '0;
          siren         <= 1'b0;
          alarm_latched <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_alarm_count (
    .clk (clk),
    .rst (rst),
    .inc (alarm_entry),
    .clr (cnt_clr),
    .q   (alarm_count)
  );

endmodule

// File: tb/tb_alarm_monitor.sv
// tb/tb_alarm_monitor.sv - self-checking bench for alarm_monitor with a behavioural reference model
module tb_alarm_monitor;

  localparam int D0 = 3;
  localparam int S0 = 16;
  localparam int W0 = 8;
  localparam int D1 = 1;
  localparam int S1 = 3;
  localparam int W1 = 2;

  logic clk = 1'b0;
  logic rst;
  logic al0, ack0, clr0;
  logic al1, ack1, clr1;
  logic siren0, lat0, siren1, lat1;
  logic [W0-1:0] cnt0;
  logic [W1-1:0] cnt1;
  logic [1:0] st0, st1;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: consecutive-high run length, latched flag, siren cycles left, alarm count
  int m_run[2];
  int m_left[2];
  int m_cnt[2];
  bit m_lat[2];

  always #5 clk = ~clk;

  alarm_monitor #(.DEBOUNCE(D0), .SIREN_CYCLES(S0), .CNT_W(W0)) dut0 (
    .clk(clk), .rst(rst), .al(al0), .ack(ack0), .cnt_clr(clr0),
    .siren(siren0), .alarm_latched(lat0), .alarm_count(cnt0), .state_o(st0)
  );

  alarm_monitor #(.DEBOUNCE(D1), .SIREN_CYCLES(S1), .CNT_W(W1)) dut1 (
    .clk(clk), .rst(rst), .al(al1), .ack(ack1), .cnt_clr(clr1),
    .siren(siren1), .alarm_latched(lat1), .alarm_count(cnt1), .state_o(st1)
  );

  function automatic int p_deb(input int i);
    return (i == 0) ? D0 : D1;
  endfunction

  function automatic int p_sir(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  function automatic int p_max(input int i);
    return (i == 0) ? ((1 << W0) - 1) : ((1 << W1) - 1);
  endfunction

  function automatic logic [1:0] exp_state(input int i);
    if (!m_lat[i]) return (m_run[i] > 0) ? 2'd1 : 2'd0;
    return (m_left[i] > 0) ? 2'd2 : 2'd3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_left[i] = 0; m_cnt[i] = 0; m_lat[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input bit a, input bit k, input bit c);
    if (!m_lat[i]) begin
      if (a) begin
        m_run[i]++;
        if (m_run[i] >= p_deb(i)) begin
          m_run[i] = 0;
          m_lat[i] = 1'b1;
          m_left[i] = p_sir(i);
          if (m_cnt[i] < p_max(i)) m_cnt[i]++;
        end
      end else begin
        m_run[i] = 0;
      end
    end else if (m_left[i] > 0) begin
      m_left[i] = k ? 0 : m_left[i] - 1;
    end else if (!a && k) begin
      m_lat[i] = 1'b0;
    end
    if (c) m_cnt[i] = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      model_step(0, al0, ack0, clr0);
      model_step(1, al1, ack1, clr1);
    end
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    al0 = 0; ack0 = 0; clr0 = 0; al1 = 0; ack1 = 0; clr1 = 0;
    model_reset();
    #3;
    n_checks++;
    if ({st0, siren0, lat0} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_dut0_flags: got %b expected 0000", {st0, siren0, lat0});
    end
    n_checks++;
    if (cnt0 !== '0) begin
      n_fail++; $display("FAIL reset_dut0_count: got %0d expected 0", cnt0);
    end
    n_checks++;
    if ({st1, siren1, lat1, cnt1} !== 6'b0) begin
      n_fail++; $display("FAIL reset_dut1_all: got %b expected 000000", {st1, siren1, lat1, cnt1});
    end
    tick();
    rst = 1'b0;
    al0 = 1; al1 = 1;
    #1;
    n_checks++;
    if ({st0, st1} !== 4'b0000) begin
      n_fail++; $display("FAIL release_no_early_change: got %b expected 0000", {st0, st1});
    end
    al0 = 0; al1 = 0;
  endtask

  task automatic test_glitch();
    al0 = 1;
    tick();
    n_checks++;
    if (st0 !== 2'd1) begin
      n_fail++; $display("FAIL glitch_qualify1: got %0d expected 1", st0);
    end
    tick();
    n_checks++;
    if (st0 !== 2'd1 || siren0 !== 1'b0) begin
      n_fail++; $display("FAIL glitch_qualify2: got state %0d siren %b expected state 1 siren 0", st0, siren0);
    end
    al0 = 0;
    tick();
    n_checks++;
    if (st0 !== 2'd0 || siren0 !== 1'b0 || cnt0 !== 8'd0) begin
      n_fail++; $display("FAIL glitch_return: got state %0d siren %b count %0d expected 0 0 0", st0, siren0, cnt0);
    end
  endtask

  task automatic test_no_ack();
    int hi;
    al0 = 1;
    tick(); tick();
    n_checks++;
    if (siren0 !== 1'b0) begin
      n_fail++; $display("FAIL siren_before_edge3: got %b expected 0", siren0);
    end
    tick();
    n_checks++;
    if (siren0 !== 1'b1 || lat0 !== 1'b1 || st0 !== 2'd2 || cnt0 !== 8'd1) begin
      n_fail++; $display("FAIL alarm_entry: got siren %b latched %b state %0d count %0d expected 1 1 2 1", siren0, lat0, st0, cnt0);
    end
    al0 = 0;
    hi = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (siren0 === 1'b1) hi++;
      else break;
    end
    n_checks++;
    if (hi != S0) begin
      n_fail++; $display("FAIL siren_length: got %0d expected %0d", hi, S0);
    end
    n_checks++;
    if (st0 !== 2'd3 || lat0 !== 1'b1 || cnt0 !== 8'd1) begin
      n_fail++; $display("FAIL after_timeout: got state %0d latched %b count %0d expected 3 1 1", st0, lat0, cnt0);
    end
    ack0 = 1;
    tick();
    n_checks++;
    if (st0 !== 2'd0 || lat0 !== 1'b0) begin
      n_fail++; $display("FAIL clear_to_idle: got state %0d latched %b expected 0 0", st0, lat0);
    end
    ack0 = 0;
  endtask

  task automatic test_early_ack();
    al0 = 1;
    tick(); tick(); tick();
    al0 = 0;
    for (int c = 2; c <= 5; c++) tick();
    n_checks++;
    if (siren0 !== 1'b1) begin
      n_fail++; $display("FAIL siren_cycle5: got %b expected 1", siren0);
    end
    ack0 = 1;
    tick();
    n_checks++;
    if (siren0 !== 1'b0 || st0 !== 2'd3) begin
      n_fail++; $display("FAIL early_ack_silence: got siren %b state %0d expected 0 3", siren0, st0);
    end
    tick();
    n_checks++;
    if (st0 !== 2'd0 || lat0 !== 1'b0 || cnt0 !== 8'd2) begin
      n_fail++; $display("FAIL early_ack_idle: got state %0d latched %b count %0d expected 0 0 2", st0, lat0, cnt0);
    end
    ack0 = 0;
  endtask

  task automatic test_persistent();
    al0 = 1;
    for (int c = 0; c < 40; c++) begin
      ack0 = (c % 9 == 8);
      tick();
      n_checks++;
      if (st0 !== exp_state(0) || cnt0 !== W0'(m_cnt[0])) begin
        n_fail++; $display("FAIL persist_cycle%0d: got state %0d count %0d expected %0d %0d", c, st0, cnt0, exp_state(0), m_cnt[0]);
      end
    end
    n_checks++;
    if (st0 !== 2'd3 || cnt0 !== 8'd3) begin
      n_fail++; $display("FAIL persist_single_count: got state %0d count %0d expected 3 3", st0, cnt0);
    end
    al0 = 0; ack0 = 1;
    tick();
    n_checks++;
    if (st0 !== 2'd0 || lat0 !== 1'b0) begin
      n_fail++; $display("FAIL persist_release: got state %0d latched %b expected 0 0", st0, lat0);
    end
    ack0 = 0;
  endtask

  task automatic test_saturation();
    int want;
    for (int n = 1; n <= 4; n++) begin
      want = (n > 3) ? 3 : n;
      al1 = 1;
      tick();
      n_checks++;
      if (st1 !== 2'd2 || cnt1 !== W1'(want)) begin
        n_fail++; $display("FAIL sat_alarm%0d: got state %0d count %0d expected 2 %0d", n, st1, cnt1, want);
      end
      al1 = 0; ack1 = 1;
      tick(); tick();
      ack1 = 0;
      n_checks++;
      if (st1 !== 2'd0) begin
        n_fail++; $display("FAIL sat_rearm%0d: got state %0d expected 0", n, st1);
      end
    end
    al1 = 1; clr1 = 1;
    tick();
    n_checks++;
    if (st1 !== 2'd2 || cnt1 !== 2'd0) begin
      n_fail++; $display("FAIL clear_wins: got state %0d count %0d expected 2 0", st1, cnt1);
    end
    al1 = 0; clr1 = 0; ack1 = 1;
    tick(); tick();
    ack1 = 0;
  endtask

  task automatic test_async_reset();
    al0 = 1;
    tick(); tick(); tick();
    al0 = 0;
    tick(); tick();
    n_checks++;
    if (siren0 !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_siren: got %b expected 1", siren0);
    end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({st0, siren0, lat0} !== 4'b0000 || cnt0 !== 8'd0) begin
      n_fail++; $display("FAIL async_reset: got state %0d siren %b latched %b count %0d expected all 0", st0, siren0, lat0, cnt0);
    end
    model_reset();
    #1;
    rst = 1'b0;
    al0 = 1;
    #1;
    n_checks++;
    if (st0 !== 2'd0) begin
      n_fail++; $display("FAIL post_release_hold: got %0d expected 0", st0);
    end
    tick();
    n_checks++;
    if (st0 !== 2'd1 || siren0 !== 1'b0) begin
      n_fail++; $display("FAIL requalify1: got state %0d siren %b expected 1 0", st0, siren0);
    end
    tick(); tick();
    n_checks++;
    if (st0 !== 2'd2 || siren0 !== 1'b1 || cnt0 !== 8'd1) begin
      n_fail++; $display("FAIL requalify_alarm: got state %0d siren %b count %0d expected 2 1 1", st0, siren0, cnt0);
    end
    al0 = 0; ack0 = 1;
    tick(); tick();
    ack0 = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      al0  = ($urandom_range(0, 1) == 1);
      ack0 = ($urandom_range(0, 7) == 0);
      clr0 = ($urandom_range(0, 31) == 0);
      al1  = ($urandom_range(0, 2) != 0);
      ack1 = ($urandom_range(0, 3) == 0);
      clr1 = ($urandom_range(0, 15) == 0);
      tick();
      n_checks++;
      if (st0 !== exp_state(0) || siren0 !== (m_left[0] > 0) || lat0 !== m_lat[0] || cnt0 !== W0'(m_cnt[0])) begin
        n_fail++; $display("FAIL rand_dut0_c%0d: got st %0d sir %b lat %b cnt %0d expected %0d %b %b %0d",
          c, st0, siren0, lat0, cnt0, exp_state(0), (m_left[0] > 0), m_lat[0], m_cnt[0]);
      end
      n_checks++;
      if (st1 !== exp_state(1) || siren1 !== (m_left[1] > 0) || lat1 !== m_lat[1] || cnt1 !== W1'(m_cnt[1])) begin
        n_fail++; $display("FAIL rand_dut1_c%0d: got st %0d sir %b lat %b cnt %0d expected %0d %b %b %0d",
          c, st1, siren1, lat1, cnt1, exp_state(1), (m_left[1] > 0), m_lat[1], m_cnt[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_no_ack();
    test_early_ack();
    test_persistent();
    test_saturation();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_monitor.md
ALARM_MONITOR -- requirements
Module: alarm_monitor

Interface
REQ-001 Parameter DEBOUNCE, default 3, consecutive high samples of al needed to raise an alarm (legal range 1..15).
REQ-002 Parameter SIREN_CYCLES, default 16, siren on-time in clk cycles (legal range 1..255).
REQ-003 Parameter CNT_W, default 8, width of alarm_count.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 al  input  1  alarm request from the security_test core (its AL output), synchronous to clk.
REQ-007 ack  input  1  operator acknowledge, level-sampled each clk edge.
REQ-008 cnt_clr  input  1  synchronous clear of alarm_count.
REQ-009 siren  output  1  registered siren drive.
REQ-010 alarm_latched  output  1  registered; high from alarm qualification until cleared.
REQ-011 alarm_count  output  CNT_W  registered count of qualified alarms, saturating.
REQ-012 state_o  output  2  registered current FSM state, for debug and bench checks.

Function
REQ-013 FSM states SHALL be IDLE=0, QUALIFY=1, ALARM=2, SILENCED=3.
REQ-014 IDLE: al=1 -> QUALIFY with debounce count 1; if DEBOUNCE=1, go directly to ALARM instead.
REQ-015 QUALIFY: al=0 -> IDLE, count cleared; al=1 with count=DEBOUNCE-1 -> ALARM; else count+1.
REQ-016 Latency: al high at DEBOUNCE consecutive edges -> siren and alarm_latched high after the DEBOUNCE-th edge (DEBOUNCE=3: after edge 3).
REQ-017 Entry to ALARM SHALL load siren timer with SIREN_CYCLES and increment alarm_count by 1, saturating at 2^CNT_W-1.
REQ-018 ALARM: siren=1; timer decrements each cycle; ack=1 or timer reaching 1 -> SILENCED; siren is low after that edge.
REQ-019 Siren SHALL be high for exactly SIREN_CYCLES cycles when ack is never asserted.
REQ-020 Simultaneous ack and timer expiry in ALARM -> SILENCED (single transition, no double count).
REQ-021 SILENCED: siren=0, alarm_latched=1; al=0 and ack=1 on the same edge -> IDLE and alarm_latched=0; otherwise stay.
REQ-022 al remaining high in SILENCED SHALL NOT retrigger ALARM or increment alarm_count.
REQ-023 ack in IDLE or QUALIFY SHALL be ignored.
REQ-024 cnt_clr=1 sets alarm_count to 0; if coincident with an ALARM entry, the result is 0 (clear wins).
REQ-025 state_o SHALL equal the state register.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, siren=0, alarm_latched=0, alarm_count=0, debounce count=0, timer=0, independent of clk.
REQ-027 Reset mid-ALARM SHALL drop siren asynchronously; after release, a new alarm requires full DEBOUNCE qualification.
REQ-028 First state change after reset release SHALL occur no earlier than the first rising clk edge with rst=0.

Structure
REQ-029 State encodings (IDLE/QUALIFY/ALARM/SILENCED) and default DEBOUNCE/SIREN_CYCLES values SHALL live in shared package security_pkg, reused by security_test benches.
REQ-030 The saturating, clearable alarm_count SHALL be a sub-module sat_counter (params WIDTH; ports clk, rst, inc, clr, q).
REQ-031 FSM, debounce counter and siren timer remain in alarm_monitor; no other sub-modules.

Verification
REQ-032 Glitch: defaults, al high 2 cycles then low -> state returns IDLE, siren=0, alarm_count=0.
REQ-033 Qualified alarm, no ack: al high 3 cycles -> siren=1 after edge 3, held exactly 16 cycles, alarm_count=1, alarm_latched=1, state SILENCED.
REQ-034 Early ack: ack=1 at 5th siren cycle -> siren=0 next edge; then al=0 with ack=1 -> IDLE, alarm_latched=0.
REQ-035 Persistent al: al held high 40 cycles with ack pulses -> exactly one count, no retrigger until al=0 and ack clear to IDLE.
REQ-036 Saturation/clear: CNT_W=2, four qualified alarms -> alarm_count=3; cnt_clr coincident with 5th ALARM entry -> alarm_count=0.
REQ-037 Async reset: rst pulsed mid-ALARM between clk edges -> siren=0 and state_o=0 before next edge; all outputs zero.
